// File: rtl/intr_pkg.sv
// Shared types and widths for the CPU-side interrupt entry/exit sequencer.
package intr_pkg;

    localparam int unsigned IRQ_W   = 8;
    localparam int unsigned VEC_W   = 3;
    localparam int unsigned DEPTH_W = 4;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] VEC_BASE_DEFAULT = 32'h0000_0100;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Vector table entry address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] vec_addr(
        input logic [ADDR_W-1:0] base,
        input logic [VEC_W-1:0]  vec,
        input int unsigned       stride_log2
    );
        return base + (ADDR_W'(vec) << stride_log2);
    endfunction

endpackage

// File: rtl/interrupt_sequencer_isr_stack.sv
// LIFO of in-service vectors; top reads 0 while empty.
module isr_stack
    import intr_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [VEC_W-1:0]   din,
    output logic [VEC_W-1:0]   top,
    output logic [DEPTH_W-1:0] depth,
    output logic               empty,
    output logic               full
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 2 ** IDX_W;

    logic [VEC_W-1:0]   mem [SLOTS];
    logic [DEPTH_W-1:0] count;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign wr_idx = count[IDX_W-1:0];
    assign rd_idx = IDX_W'(count - DEPTH_W'(1));
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_W'(DEPTH));
    assign depth  = count;
    assign top    = empty ? '0 : mem[rd_idx];

    // Push and pop are mutually exclusive from the sequencer; guards make over/underflow inert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            count       <= count + DEPTH_W'(1);
        end else if (pop && !empty) begin
            count <= count - DEPTH_W'(1);
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: request/take handshake to the core and nested in-service tracking.
module interrupt_sequencer
    import intr_pkg::*;
#(
    parameter logic [ADDR_W-1:0] VEC_BASE        = VEC_BASE_DEFAULT,
    parameter int unsigned       VEC_STRIDE_LOG2 = 2,
    parameter int unsigned       NEST_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_W-1:0]   irq_pending,
    input  logic [VEC_W-1:0]   irq_vector,
    output logic               irq_ack,
    input  logic               int_enable,
    input  logic               insn_boundary,
    output logic               int_req,
    input  logic               int_taken,
    input  logic               int_return,
    output logic [ADDR_W-1:0]  handler_addr,
    output logic               in_service,
    output logic [VEC_W-1:0]   cur_level,
    output logic [DEPTH_W-1:0] depth,
    output logic               spurious,
    output logic               err_underflow
);

    state_t             state;
    state_t             state_next;
    logic               candidate_c;
    logic               push_c;
    logic               pop_c;
    logic               uflow_c;
    logic               withdraw_c;
    logic [VEC_W-1:0]   stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_empty;
    logic               stk_full;

    isr_stack #(
        .DEPTH (NEST_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (irq_vector),
        .top   (stk_top),
        .depth (stk_depth),
        .empty (stk_empty),
        .full  (stk_full)
    );

    // Only a strictly higher-priority (lower-numbered) vector may preempt the current level.
    assign candidate_c = (irq_pending != '0) && int_enable && !stk_full
                      && (stk_empty || (irq_vector < stk_top));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        uflow_c    = 1'b0;
        withdraw_c = 1'b0;
        irq_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (int_return) begin
                    if (stk_empty) begin
                        uflow_c = 1'b1;
                    end else begin
                        pop_c = 1'b1;
                    end
                end
                if (candidate_c && insn_boundary) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // Return beats withdraw beats take; a withdrawn request never acks.
                if (int_return) begin
                    if (stk_empty) begin
                        uflow_c = 1'b1;
                    end else begin
                        pop_c = 1'b1;
                    end
                    withdraw_c = 1'b1;
                    state_next = IDLE;
                end else if (!candidate_c) begin
                    withdraw_c = 1'b1;
                    state_next = IDLE;
                end else if (int_taken) begin
                    irq_ack    = 1'b1;
                    push_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spurious      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            spurious <= withdraw_c;
            if (uflow_c) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign int_req      = (state == REQ);
    assign in_service   = !stk_empty;
    assign cur_level    = stk_top;
    assign depth        = stk_depth;
    assign handler_addr = vec_addr(VEC_BASE, irq_vector, VEC_STRIDE_LOG2);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Table-driven, scoreboarded bench for interrupt_sequencer plus an async-reset corner sequence.
module tb_interrupt_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_pending;
    logic [2:0]  irq_vector;
    logic        irq_ack;
    logic        int_enable;
    logic        insn_boundary;
    logic        int_req;
    logic        int_taken;
    logic        int_return;
    logic [31:0] handler_addr;
    logic        in_service;
    logic [2:0]  cur_level;
    logic [3:0]  depth;
    logic        spurious;
    logic        err_underflow;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0]  pend;
        logic [2:0]  vec;
        logic        en;
        logic        bnd;
        logic        tkn;
        logic        ret;
        logic        req;
        logic        ack;
        logic [3:0]  dep;
        logic [2:0]  lvl;
        logic        sp;
        logic        err;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    interrupt_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_pending   (irq_pending),
        .irq_vector    (irq_vector),
        .irq_ack       (irq_ack),
        .int_enable    (int_enable),
        .insn_boundary (insn_boundary),
        .int_req       (int_req),
        .int_taken     (int_taken),
        .int_return    (int_return),
        .handler_addr  (handler_addr),
        .in_service    (in_service),
        .cur_level     (cur_level),
        .depth         (depth),
        .spurious      (spurious),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] pend, input logic [2:0] vec,
                       input logic en, input logic bnd, input logic tkn, input logic ret,
                       input logic req, input logic ack, input logic [3:0] dep,
                       input logic [2:0] lvl, input logic sp, input logic err,
                       input logic [31:0] addr);
        vec_t v;
        v.pend = pend; v.vec = vec; v.en = en; v.bnd = bnd; v.tkn = tkn; v.ret = ret;
        v.req = req; v.ack = ack; v.dep = dep; v.lvl = lvl; v.sp = sp; v.err = err;
        v.addr = addr;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        irq_pending   = v.pend;
        irq_vector    = v.vec;
        int_enable    = v.en;
        insn_boundary = v.bnd;
        int_taken     = v.tkn;
        int_return    = v.ret;
    endtask

    task automatic compare_row(input int i, input vec_t e);
        check($sformatf("row%0d int_req", i),       32'(int_req),       32'(e.req));
        check($sformatf("row%0d irq_ack", i),       32'(irq_ack),       32'(e.ack));
        check($sformatf("row%0d depth", i),         32'(depth),         32'(e.dep));
        check($sformatf("row%0d cur_level", i),     32'(cur_level),     32'(e.lvl));
        check($sformatf("row%0d in_service", i),    32'(in_service),    32'(e.dep != 4'd0));
        check($sformatf("row%0d spurious", i),      32'(spurious),      32'(e.sp));
        check($sformatf("row%0d err_underflow", i), 32'(err_underflow), 32'(e.err));
        if (e.req) begin
            check($sformatf("row%0d handler_addr", i), handler_addr, e.addr);
        end
    endtask

    initial begin
        vec_t e;
        n_cmp = 0;
        n_bad = 0;

        //   pend   vec  en bnd tkn ret | req ack dep  lvl  sp err addr
        // reset state
        add(8'h00, 3'd0, 0, 0, 0, 0,   0, 0, 4'd0, 3'd0, 0, 0, 32'h0);
        // basic take of vector 3
        add(8'h08, 3'd3, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 0, 32'h0);
        add(8'h08, 3'd3, 1, 1, 0, 0,   1, 0, 4'd0, 3'd0, 0, 0, 32'h10C);
        add(8'h08, 3'd3, 1, 1, 1, 0,   1, 1, 4'd0, 3'd0, 0, 0, 32'h10C);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd1, 3'd3, 0, 0, 32'h0);
        // preemption by vector 1
        add(8'h02, 3'd1, 1, 1, 0, 0,   0, 0, 4'd1, 3'd3, 0, 0, 32'h0);
        add(8'h02, 3'd1, 1, 1, 0, 0,   1, 0, 4'd1, 3'd3, 0, 0, 32'h104);
        add(8'h02, 3'd1, 1, 1, 1, 0,   1, 1, 4'd1, 3'd3, 0, 0, 32'h104);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd2, 3'd1, 0, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 1,   0, 0, 4'd2, 3'd1, 0, 0, 32'h0);
        // lower-priority vector 5 held off until fully popped
        add(8'h20, 3'd5, 1, 1, 0, 0,   0, 0, 4'd1, 3'd3, 0, 0, 32'h0);
        add(8'h20, 3'd5, 1, 1, 0, 0,   0, 0, 4'd1, 3'd3, 0, 0, 32'h0);
        add(8'h20, 3'd5, 1, 1, 0, 1,   0, 0, 4'd1, 3'd3, 0, 0, 32'h0);
        add(8'h20, 3'd5, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 0, 32'h0);
        // withdraw by dropping enable; take in same cycle must not ack
        add(8'h20, 3'd5, 0, 1, 1, 0,   1, 0, 4'd0, 3'd0, 0, 0, 32'h114);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 1, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 0, 32'h0);
        // nest 7,6,5,4 to full depth
        add(8'h80, 3'd7, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 0, 32'h0);
        add(8'h80, 3'd7, 1, 1, 1, 0,   1, 1, 4'd0, 3'd0, 0, 0, 32'h11C);
        add(8'h40, 3'd6, 1, 1, 0, 0,   0, 0, 4'd1, 3'd7, 0, 0, 32'h0);
        add(8'h40, 3'd6, 1, 1, 1, 0,   1, 1, 4'd1, 3'd7, 0, 0, 32'h118);
        add(8'h20, 3'd5, 1, 1, 0, 0,   0, 0, 4'd2, 3'd6, 0, 0, 32'h0);
        add(8'h20, 3'd5, 1, 1, 1, 0,   1, 1, 4'd2, 3'd6, 0, 0, 32'h114);
        add(8'h10, 3'd4, 1, 1, 0, 0,   0, 0, 4'd3, 3'd5, 0, 0, 32'h0);
        add(8'h10, 3'd4, 1, 1, 1, 0,   1, 1, 4'd3, 3'd5, 0, 0, 32'h110);
        // vector 0 blocked at full depth, issues after one return
        add(8'h01, 3'd0, 1, 1, 0, 0,   0, 0, 4'd4, 3'd4, 0, 0, 32'h0);
        add(8'h01, 3'd0, 1, 1, 0, 0,   0, 0, 4'd4, 3'd4, 0, 0, 32'h0);
        add(8'h01, 3'd0, 1, 1, 0, 1,   0, 0, 4'd4, 3'd4, 0, 0, 32'h0);
        add(8'h01, 3'd0, 1, 1, 0, 0,   0, 0, 4'd3, 3'd5, 0, 0, 32'h0);
        add(8'h01, 3'd0, 1, 1, 1, 0,   1, 1, 4'd3, 3'd5, 0, 0, 32'h100);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd4, 3'd0, 0, 0, 32'h0);
        // unwind, then underflow
        add(8'h00, 3'd0, 1, 1, 0, 1,   0, 0, 4'd4, 3'd0, 0, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 1,   0, 0, 4'd3, 3'd5, 0, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 1,   0, 0, 4'd2, 3'd6, 0, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 1,   0, 0, 4'd1, 3'd7, 0, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 1,   0, 0, 4'd0, 3'd0, 0, 0, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        // return during REQ at depth 1: pop, withdraw, no ack
        add(8'h08, 3'd3, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        add(8'h08, 3'd3, 1, 1, 1, 0,   1, 1, 4'd0, 3'd0, 0, 1, 32'h10C);
        add(8'h02, 3'd1, 1, 1, 0, 0,   0, 0, 4'd1, 3'd3, 0, 1, 32'h0);
        add(8'h02, 3'd1, 1, 1, 1, 1,   1, 0, 4'd1, 3'd3, 0, 1, 32'h104);
        add(8'h00, 3'd0, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 1, 1, 32'h0);
        // int_taken outside REQ ignored; no request off an instruction boundary
        add(8'h00, 3'd0, 1, 1, 1, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        add(8'h08, 3'd3, 1, 0, 0, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        add(8'h08, 3'd3, 1, 0, 0, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        add(8'h08, 3'd3, 1, 1, 0, 0,   0, 0, 4'd0, 3'd0, 0, 1, 32'h0);
        add(8'h08, 3'd3, 1, 0, 0, 0,   1, 0, 4'd0, 3'd0, 0, 1, 32'h10C);
        // build depth 2 with a request pending for the reset test
        add(8'h08, 3'd3, 1, 1, 1, 0,   1, 1, 4'd0, 3'd0, 0, 1, 32'h10C);
        add(8'h02, 3'd1, 1, 1, 0, 0,   0, 0, 4'd1, 3'd3, 0, 1, 32'h0);
        add(8'h02, 3'd1, 1, 1, 1, 0,   1, 1, 4'd1, 3'd3, 0, 1, 32'h104);
        add(8'h01, 3'd0, 1, 1, 0, 0,   0, 0, 4'd2, 3'd1, 0, 1, 32'h0);

        rst_n = 1'b0;
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compare_row(i, e);
        end

        // Async reset mid-handshake: request up, ack high, depth 2.
        @(posedge clk);
        #1;
        int_taken = 1'b1;
        #1;
        check("pre_rst int_req", 32'(int_req), 32'd1);
        check("pre_rst irq_ack", 32'(irq_ack), 32'd1);
        check("pre_rst depth",   32'(depth),   32'd2);
        check("pre_rst handler", handler_addr, 32'h100);
        rst_n = 1'b0;
        #1;
        check("rst int_req",       32'(int_req),       32'd0);
        check("rst irq_ack",       32'(irq_ack),       32'd0);
        check("rst depth",         32'(depth),         32'd0);
        check("rst cur_level",     32'(cur_level),     32'd0);
        check("rst in_service",    32'(in_service),    32'd0);
        check("rst spurious",      32'(spurious),      32'd0);
        check("rst err_underflow", 32'(err_underflow), 32'd0);
        irq_pending   = 8'h00;
        irq_vector    = 3'd0;
        int_taken     = 1'b0;
        int_return    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst int_req", 32'(int_req), 32'd0);
        check("post_rst depth",   32'(depth),   32'd0);
        @(posedge clk);
        #1;
        check("idle int_req",     32'(int_req),       32'd0);
        check("idle depth",       32'(depth),         32'd0);
        check("idle err",         32'(err_underflow), 32'd0);

        if (exp_q.size() != 0) begin
            check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
CPU-side interrupt entry/exit sequencer. It sits directly downstream of the 8-source interrupt controller and consumes that controller's irq_out and irq_vector, returning its irq_ack.
- Arbitrates pending requests against the CPU global enable and instruction boundaries, and drives a take-interrupt handshake to the core.
- Supplies the handler address.
- Keeps a LIFO of in-service vectors so that only strictly higher-priority sources (lower vector number) can preempt, and pops that LIFO on return-from-interrupt.

Parameters:
VEC_BASE, 32'h0000_0100, byte address of vector table entry 0
VEC_STRIDE_LOG2, 2, log2 of bytes per vector table entry
NEST_DEPTH, 4, maximum in-service nesting depth (1..8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
irq_pending  in  8  active (pending and unmasked) IRQs from the controller
irq_vector  in  3  highest-priority active vector from the controller (0 = highest)
irq_ack  out  1  acknowledge to the controller; clears pending[irq_vector]
int_enable  in  1  CPU global interrupt enable flag
insn_boundary  in  1  CPU is at an instruction boundary and may be interrupted
int_req  out  1  take-interrupt request to the CPU
int_taken  in  1  CPU accepts the request (context saved, jumping to handler_addr)
int_return  in  1  CPU executed IRET (one-cycle pulse)
handler_addr  out  32  VEC_BASE + (irq_vector << VEC_STRIDE_LOG2), modulo 2^32
in_service  out  1  depth != 0
cur_level  out  3  vector on top of the LIFO (0 when empty)
depth  out  4  number of entries in the LIFO
spurious  out  1  one-cycle pulse when a request is withdrawn without being taken
err_underflow  out  1  sticky: int_return received while depth == 0

Behaviour:
Reset values
- All outputs 0, FSM in IDLE, LIFO empty.
- handler_addr is combinational; it is defined only while int_req = 1.
- Reset asserted mid-handshake drops int_req and irq_ack immediately (asynchronous).

Definitions
- candidate = (irq_pending != 0) & int_enable & (depth < NEST_DEPTH) & (depth == 0 | irq_vector < cur_level).
- Preemption requires a strictly lower vector number. An equal or lower-priority vector waits for the pop.

FSM states
- IDLE: if candidate & insn_boundary, go to REQ at the next edge. int_req = 0.
- REQ: int_req = 1 (decoded from state, registered). handler_addr tracks irq_vector combinationally; the CPU samples it in the int_taken cycle.
- Transitions out of REQ, in priority order:
  1. int_return → pop and perform the normal pop actions. Withdraw to IDLE, irq_ack held 0, int_taken ignored, spurious pulses.
  2. !candidate (mask change, enable dropped, pending cleared) → withdraw to IDLE, spurious = 1 for one cycle.
  3. int_taken → irq_ack = 1 combinationally in this same cycle. Push irq_vector at the edge and go to IDLE. The controller clears the same bit at the same edge, so the acked and pushed vectors are always identical.

Latency
- candidate visible at edge N → int_req high after edge N+1.
- Accepted interrupt: irq_ack and int_taken high in the same cycle; depth increments at the next edge.
- Earliest nested request: REQ again one cycle after returning to IDLE.

LIFO (pop)
- int_return in IDLE (or per rule 1 in REQ): pop and decrement depth.
- int_return at depth == 0: set err_underflow, depth stays 0. err_underflow clears only on reset.

Boundaries and width rules
- depth == NEST_DEPTH: no candidate, requests are held off. This is not an error.
- int_taken outside REQ is ignored.
- depth saturates by construction.

Decomposition:
- Shared package intr_pkg holds:
  - FSM enum: IDLE, REQ.
  - IRQ_W = 8.
  - VEC_W = 3.
  - Default VEC_BASE.
- Sub-module isr_stack: parameterised LIFO of VEC_W-bit entries.
  - Ports: push, pop, din, top, depth, empty, full.
  - Simultaneous push and pop is not required; the FSM never issues both.

Test Plan:
Basic take
- int_enable = 1, insn_boundary = 1, irq_pending = 8'h08, irq_vector = 3 → int_req rises after 1 cycle, handler_addr = 0x10C.
- int_taken → irq_ack pulse in the same cycle; depth = 1, cur_level = 3.

Preemption
- In service at vector 3, raise vector 1 → new request with handler 0x104, depth = 2.
- Raising vector 5 instead → no request until int_return pops back to depth 0.

Withdraw
- While in REQ, drop int_enable (or zero irq_pending) → int_req falls next cycle, spurious pulses once, irq_ack never asserts, depth unchanged.

Nesting limit
- Nest vectors 7, 6, 5, 4 (depth = 4), then raise vector 0 → int_req stays 0.
- One int_return → request for vector 0 issues.

Underflow and return during REQ
- int_return at depth 0 → err_underflow = 1 and sticky, depth = 0.
- int_return during REQ at depth 1 → pop, withdraw, no irq_ack.

Async reset
- Assert rst_n low while int_req = 1 and depth = 2 → all outputs 0 immediately; after release, the FSM is in IDLE with depth 0.
